// File: rtl/rv16_pc_unit.sv
// Program-counter unit: owns the fetch PC, issues fetch requests over a
// valid/ready handshake, applies redirects from execute and predicts returns
// from a small circular return-address stack.
//
// Ports:
//   i_clk, i_rst         clock (rising edge), asynchronous active-high reset
//   o_fetch_valid        fetch request valid (1 from the first edge after reset)
//   o_fetch_addr         fetch address, always the current PC
//   i_fetch_ready        fetch side accepts the request
//   i_redir_*            redirect request: type, PC of redirecting instruction
//   i_rs1_data           rs1 operand for JALR / RET fallback
//   i_immediate          sign-extended offset
//   i_branch_taken       branch outcome (BRANCH only)
//   i_call               push link address onto the RAS (JAL/JALR/RET)
//   i_trap_vector        trap handler address
//   o_misalign           one-cycle pulse when a misaligned target is trapped
//   o_misalign_addr      offending target, held until the next misalign
//   o_ras_hit            one-cycle pulse when a RET is served from the RAS
//   o_ras_count          number of valid RAS entries
module rv16_pc_unit #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter bit               C_EXT        = 1'b0,
    parameter int unsigned      RAS_DEPTH    = 4,
    localparam int unsigned     PtrW         = $clog2(RAS_DEPTH),
    localparam int unsigned     CntW         = PtrW + 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_fetch_valid,
    output logic [XLEN-1:0] o_fetch_addr,
    input  logic            i_fetch_ready,
    input  logic            i_redir_valid,
    input  logic [2:0]      i_redir_type,
    input  logic [XLEN-1:0] i_redir_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_immediate,
    input  logic            i_branch_taken,
    input  logic            i_call,
    input  logic [XLEN-1:0] i_trap_vector,
    output logic            o_misalign,
    output logic [XLEN-1:0] o_misalign_addr,
    output logic            o_ras_hit,
    output logic [CntW-1:0] o_ras_count
);

    typedef enum logic [2:0] {
        RedirBranch = 3'b000,
        RedirJal    = 3'b001,
        RedirJalr   = 3'b010,
        RedirRet    = 3'b011,
        RedirTrap   = 3'b100
    } redir_e;

    localparam logic [XLEN-1:0] AlignMask = C_EXT ? XLEN'(1) : XLEN'(3);
    localparam logic [XLEN-1:0] InstrStep = XLEN'(4);
    localparam logic [CntW-1:0] CntFull   = CntW'(RAS_DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] misalign_addr_q, misalign_addr_d;
    logic            ras_hit_q, ras_hit_d;
    logic [PtrW-1:0] top_q, top_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] ras_q [RAS_DEPTH];

    logic            is_redir;
    logic            check_align;
    logic            push;
    logic            pop;
    logic            ras_we;
    logic [PtrW-1:0] ras_widx;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link_addr;
    logic [XLEN-1:0] jalr_target;
    logic [XLEN-1:0] trap_aligned;

    assign link_addr    = i_redir_pc + InstrStep;
    assign jalr_target  = (i_rs1_data + i_immediate) & ~XLEN'(1);
    assign trap_aligned = i_trap_vector & ~AlignMask;

    // Target decode.
    always_comb begin
        is_redir    = 1'b0;
        check_align = 1'b1;
        push        = 1'b0;
        pop         = 1'b0;
        ras_hit_d   = 1'b0;
        target      = '0;
        if (i_redir_valid) begin
            case (i_redir_type)
                RedirBranch: begin
                    is_redir = 1'b1;
                    target   = i_branch_taken ? (i_redir_pc + i_immediate) : link_addr;
                end
                RedirJal: begin
                    is_redir = 1'b1;
                    target   = i_redir_pc + i_immediate;
                    push     = i_call;
                end
                RedirJalr: begin
                    is_redir = 1'b1;
                    target   = jalr_target;
                    push     = i_call;
                end
                RedirRet: begin
                    is_redir = 1'b1;
                    push     = i_call;
                    if (cnt_q != '0) begin
                        target    = ras_q[top_q];
                        pop       = 1'b1;
                        ras_hit_d = 1'b1;
                    end else begin
                        target = jalr_target;
                    end
                end
                RedirTrap: begin
                    is_redir    = 1'b1;
                    target      = trap_aligned;
                    check_align = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // PC next-state and misalign trapping.
    always_comb begin
        pc_d            = pc_q;
        misalign_d      = 1'b0;
        misalign_addr_d = misalign_addr_q;
        if (is_redir) begin
            if (check_align && ((target & AlignMask) != '0)) begin
                pc_d            = trap_aligned;
                misalign_d      = 1'b1;
                misalign_addr_d = target;
            end else begin
                pc_d = target;
            end
        end else if (valid_q && i_fetch_ready) begin
            pc_d = pc_q + InstrStep;
        end
    end

    // RAS pointer/count update. Pop+push rewrites the current top in place.
    always_comb begin
        top_d    = top_q;
        cnt_d    = cnt_q;
        ras_we   = 1'b0;
        ras_widx = top_q;
        if (pop && push) begin
            ras_we   = 1'b1;
            ras_widx = top_q;
        end else if (pop) begin
            top_d = top_q - PtrW'(1);
            cnt_d = cnt_q - CntW'(1);
        end else if (push) begin
            // When full the pointer simply advances onto the oldest entry.
            ras_we   = 1'b1;
            ras_widx = top_q + PtrW'(1);
            top_d    = top_q + PtrW'(1);
            cnt_d    = (cnt_q == CntFull) ? cnt_q : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pc_q            <= RESET_VECTOR;
            valid_q         <= 1'b0;
            misalign_q      <= 1'b0;
            misalign_addr_q <= '0;
            ras_hit_q       <= 1'b0;
            top_q           <= '0;
            cnt_q           <= '0;
        end else begin
            pc_q            <= pc_d;
            valid_q         <= 1'b1;
            misalign_q      <= misalign_d;
            misalign_addr_q <= misalign_addr_d;
            ras_hit_q       <= ras_hit_d;
            top_q           <= top_d;
            cnt_q           <= cnt_d;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                ras_q[i] <= '0;
            end
        end else if (ras_we) begin
            ras_q[ras_widx] <= link_addr;
        end
    end

    assign o_fetch_valid   = valid_q;
    assign o_fetch_addr    = pc_q;
    assign o_misalign      = misalign_q;
    assign o_misalign_addr = misalign_addr_q;
    assign o_ras_hit       = ras_hit_q;
    assign o_ras_count     = cnt_q;

endmodule
